// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD stopwatch slice.
//   state_t : FSM state encoding (ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE), 2 bits
//   BCD_W   : bits per BCD digit
//   BCD_MAX : largest legal digit value
package bcd_pkg;

  localparam int unsigned BCD_W = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit of the stopwatch cascade.
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset
//   clr    : synchronous clear to 0
//   inc    : advance by one this cycle, wrapping 9 -> 0
//   q      : current digit value
//   at_max : q is 9, so the next increment carries into the digit above
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] q,
  output logic       at_max
);

  assign at_max = (q == BCD_MAX);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= 4'd0;
    end else if (inc) begin
      q <= at_max ? 4'd0 : q + 4'd1;
    end
  end

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// Start/stop/clear stopwatch over a cascade of BCD digit counters.
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   start   : level, enter/resume RUN from IDLE or PAUSE
//   stop    : level, RUN -> PAUSE
//   clear   : level, zero count and prescaler, go IDLE from any state
//   limit   : BCD terminal value, all-zero means free run
//   count   : packed BCD count, digit i at [4i+3:4i]
//   running : registered, high while in RUN
//   done    : registered, high while in DONE
module bcd_stopwatch_ctrl
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic [4*DIGITS-1:0]   limit,
  output logic [4*DIGITS-1:0]   count,
  output logic                  running,
  output logic                  done
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PSC_LAST = PW'(PRESCALE - 1);

  state_t              state;
  logic [PW-1:0]       psc;
  logic                tick;
  logic                hit;
  logic [DIGITS-1:0]   inc;
  logic [DIGITS-1:0]   at_max;
  logic [4*DIGITS-1:0] next_count;

  assign tick = (state == ST_RUN) && (psc == PSC_LAST);

  // Digit i advances only when every lower digit is about to wrap; next_count
  // is the value the cascade will hold after this edge, so the terminal match
  // is detected on the same edge that produces it.
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic [3:0] q_i;

    if (i == 0) begin : g_lsd
      assign inc[i] = tick;
    end else begin : g_upper
      assign inc[i] = tick & (&at_max[i-1:0]);
    end

    bcd_digit u_digit (
      .clk    (clk),
      .rst    (rst),
      .clr    (clear),
      .inc    (inc[i]),
      .q      (q_i),
      .at_max (at_max[i])
    );

    assign count[BCD_W*i +: BCD_W]      = q_i;
    assign next_count[BCD_W*i +: BCD_W] = !inc[i]   ? q_i  :
                                          at_max[i] ? 4'd0 : q_i + 4'd1;
  end

  // A limit digit above 9 can never equal a BCD count, so such a limit
  // simply never matches and the block free-runs.
  assign hit = tick && (limit != '0) && (next_count == limit);

  // Outputs are assigned alongside every state change so they always
  // reflect the state register without a decode stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      psc     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else if (clear) begin
      state   <= ST_IDLE;
      psc     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_PAUSE: begin
          // Prescaler is held here so the tick phase survives a pause.
          if (start && !stop) begin
            state   <= ST_RUN;
            running <= 1'b1;
          end
        end
        ST_RUN: begin
          psc <= tick ? '0 : psc + PW'(1);
          // The tick's increment commits regardless; reaching the limit
          // outranks a simultaneous stop.
          if (hit) begin
            state   <= ST_DONE;
            running <= 1'b0;
            done    <= 1'b1;
          end else if (stop) begin
            state   <= ST_PAUSE;
            running <= 1'b0;
          end
        end
        default: begin
          // ST_DONE: left only through clear or rst.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Two instances share stimulus: dut_a (PRESCALE=2) and dut_b (PRESCALE=5),
// both DIGITS=2. A cycle-level behavioural model predicts every output after
// each edge; predictions go into per-instance queues that a negedge monitor
// drains and compares.
module tb_bcd_stopwatch_ctrl;

  localparam int MOD = 100;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  typedef struct packed {
    int st;
    int psc;
    int val;
  } mdl_t;

  typedef struct packed {
    logic [7:0] cnt;
    logic       run;
    logic       dn;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, start, stop, clear;
  logic [7:0] limit;
  logic [7:0] count_a, count_b;
  logic       running_a, running_b, done_a, done_b;

  int n_checks = 0;
  int n_fail   = 0;

  mdl_t ma, mb;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;

  bcd_stopwatch_ctrl #(.DIGITS(2), .PRESCALE(2)) dut_a (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
    .limit(limit), .count(count_a), .running(running_a), .done(done_a)
  );

  bcd_stopwatch_ctrl #(.DIGITS(2), .PRESCALE(5)) dut_b (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
    .limit(limit), .count(count_b), .running(running_b), .done(done_b)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Integer value of a BCD limit, or -1 when a digit is not decimal.
  function automatic int lim_val(input logic [7:0] l);
    if (l[3:0] > 4'd9 || l[7:4] > 4'd9) return -1;
    return int'(l[7:4]) * 10 + int'(l[3:0]);
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  // One clock edge of the stopwatch rules, expressed on an integer count.
  function automatic mdl_t step(input mdl_t m, input int ps, input logic r, input logic c,
                                input logic sp, input logic st, input logic [7:0] lim);
    mdl_t n = m;
    if (r || c) begin
      n.st = M_IDLE; n.psc = 0; n.val = 0;
    end else if (m.st == M_IDLE || m.st == M_PAUSE) begin
      if (st && !sp) n.st = M_RUN;
    end else if (m.st == M_RUN) begin
      if (m.psc == ps - 1) begin
        n.psc = 0;
        n.val = (m.val + 1) % MOD;
        if (lim != 8'h00 && lim_val(lim) == n.val) n.st = M_DONE;
        else if (sp) n.st = M_PAUSE;
      end else begin
        n.psc = m.psc + 1;
        if (sp) n.st = M_PAUSE;
      end
    end
    return n;
  endfunction

  function automatic exp_t expect_of(input mdl_t m);
    exp_t e;
    e.cnt = to_bcd(m.val);
    e.run = (m.st == M_RUN);
    e.dn  = (m.st == M_DONE);
    return e;
  endfunction

  // Advance one clock: predict from the inputs seen at the edge, push the
  // prediction once the edge has happened, then release for new inputs.
  task automatic cycle();
    mdl_t na, nb;
    na = step(ma, 2, rst, clear, stop, start, limit);
    nb = step(mb, 5, rst, clear, stop, start, limit);
    @(posedge clk);
    ma = na;
    mb = nb;
    qa.push_back(expect_of(ma));
    qb.push_back(expect_of(mb));
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic pulse_start();
    start = 1'b1; cycle(); start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; cycle(); clear = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      check("a_count",   count_a,   e.cnt);
      check("a_running", {7'd0, running_a}, {7'd0, e.run});
      check("a_done",    {7'd0, done_a},    {7'd0, e.dn});
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      check("b_count",   count_b,   e.cnt);
      check("b_running", {7'd0, running_b}, {7'd0, e.run});
      check("b_done",    {7'd0, done_b},    {7'd0, e.dn});
    end
  end

  initial begin
    int guard;
    ma = '0; mb = '0;
    rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; limit = 8'h00;

    // Reset and idle hold.
    cycles(2);
    rst = 1'b0;
    check("t1_count",   count_a, 8'h00);
    check("t1_running", {7'd0, running_a}, 8'd0);
    check("t1_done",    {7'd0, done_a},    8'd0);
    cycles(10);
    check("t1_idle_count", count_a, 8'h00);

    // Free run with carry and full wrap.
    pulse_start();
    cycles(20);
    check("t2_carry_10", count_a, 8'h10);
    cycles(380);
    check("t2_wrap_00",   count_a, 8'h00);
    check("t2_still_run", {7'd0, running_a}, 8'd1);

    // Terminal at 15.
    pulse_clear();
    limit = 8'h15;
    pulse_start();
    guard = 0;
    while (ma.st != M_DONE && guard < 100) begin cycle(); guard++; end
    check("t3_reached", {7'd0, done_a}, 8'd1);
    check("t3_count",   count_a, 8'h15);
    for (int i = 0; i < 20; i++) begin
      start = i[0];
      cycle();
    end
    start = 1'b0;
    check("t3_hold", count_a, 8'h15);
    pulse_clear();
    check("t3_clr_count", count_a, 8'h00);
    check("t3_clr_done",  {7'd0, done_a}, 8'd0);

    // Pause preserves prescaler phase (dut_b, PRESCALE=5).
    limit = 8'h00;
    pulse_start();
    guard = 0;
    while (mb.val != 7 && guard < 100) begin cycle(); guard++; end
    check("t4_at_07", count_b, 8'h07);
    cycle();
    stop = 1'b1; cycle(); stop = 1'b0;
    check("t4_paused", {7'd0, running_b}, 8'd0);
    cycles(30);
    check("t4_hold_07", count_b, 8'h07);
    pulse_start();
    cycles(2);
    check("t4_not_yet", count_b, 8'h07);
    cycle();
    check("t4_step_08", count_b, 8'h08);

    // Command priority.
    pulse_clear();
    pulse_start();
    cycles(3);
    start = 1'b1; stop = 1'b1; cycle();
    check("t5_ss_pause", {7'd0, running_a}, 8'd0);
    stop = 1'b0; clear = 1'b1; cycle();
    clear = 1'b0; start = 1'b0;
    check("t5_clr_count", count_a, 8'h00);
    check("t5_clr_run",   {7'd0, running_a}, 8'd0);
    start = 1'b1; stop = 1'b1; cycle();
    start = 1'b0; stop = 1'b0;
    check("t5_ss_idle", {7'd0, running_a}, 8'd0);

    // Reset mid-run.
    pulse_start();
    guard = 0;
    while (ma.val != 42 && guard < 200) begin cycle(); guard++; end
    check("t6_at_42", count_a, 8'h42);
    rst = 1'b1; cycle(); rst = 1'b0;
    check("t6_count",   count_a, 8'h00);
    check("t6_running", {7'd0, running_a}, 8'd0);
    check("t6_done",    {7'd0, done_a},    8'd0);
    pulse_start();
    cycle();
    check("t6_first_wait", count_a, 8'h00);
    cycle();
    check("t6_first_tick", count_a, 8'h01);

    // Randomized commands and limits.
    for (int i = 0; i < 4000; i++) begin
      rst   = ($urandom_range(199, 0) == 0);
      clear = ($urandom_range(99, 0) < 2);
      stop  = ($urandom_range(99, 0) < 5);
      start = ($urandom_range(99, 0) < 12);
      if ($urandom_range(99, 0) < 3) begin
        case ($urandom_range(3, 0))
          0: limit = 8'h00;
          1: limit = {4'($urandom_range(2, 0)), 4'($urandom_range(9, 0))};
          2: limit = {4'($urandom_range(9, 0)), 4'($urandom_range(9, 0))};
          default: limit = {4'($urandom_range(15, 10)), 4'($urandom_range(9, 0))};
        endcase
      end
      cycle();
    end
    rst = 1'b0; clear = 1'b0; stop = 1'b0; start = 1'b0;
    cycle();

    @(negedge clk);
    #1;
    n_checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d/%0d pending, expected 0/0", qa.size(), qb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
